// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared widths and glyph table for the hex display scanner
package hex_display_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Active-high segments, bit 0 = a .. bit 6 = g; entry n sits at [7n +: 7].
    localparam logic [16*SEG_W-1:0] GLYPH_ROM = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_glyph.sv
// rtl/hex_glyph.sv - combinational nibble to active-high 7-segment glyph
module hex_glyph
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = GLYPH_ROM[SEG_W*i_nibble +: SEG_W];

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed tear-free driver for NUM_DIGITS hex digits
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_POL  = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PS_W-1:0]         r_prescale;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shd_value;
    logic [NUM_DIGITS-1:0]   r_shd_dp;
    logic                    r_shd_blz;
    logic [4*NUM_DIGITS-1:0] r_act_value;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_act_blz;
    logic                    r_pending;
    logic                    r_frame_start;
    seg_t                    r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_show;
    logic [3:0]              w_nibble;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_lz_zero;
    seg_t                    w_glyph;
    seg_t                    w_seg_hi;
    logic [NUM_DIGITS-1:0]   w_dig_hi;

    assign w_tick = enable && (r_prescale == PS_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);
    // The tick cycle loads "off" into the output stage, giving the dead slot cycle.
    assign w_show = enable && !w_tick;

    always_comb begin
        w_nibble    = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        w_zero_run  = 1'b1;
        w_lz_zero   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run   = w_zero_run && (r_act_value[4*i +: 4] == 4'h0);
            w_lz_zero[i] = w_zero_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = r_act_value[4*i +: 4];
                w_cur_dp    = r_act_dp[i];
                w_cur_blank = r_act_blz && (i != 0) && w_lz_zero[i];
            end
        end
    end

    hex_glyph u_glyph (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    assign w_seg_hi = (w_show && !w_cur_blank) ? w_glyph : SEG_BLANK;
    assign w_dig_hi = w_show ? (NUM_DIGITS'(1) << r_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale    <= '0;
            r_idx         <= '0;
            r_shd_value   <= '0;
            r_shd_dp      <= '0;
            r_shd_blz     <= 1'b0;
            r_act_value   <= '0;
            r_act_dp      <= '0;
            r_act_blz     <= 1'b0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= SEG_BLANK ^ SEG_POL;
            r_dp          <= SEG_ACTIVE_LOW;
            r_dig         <= DIG_POL;
        end else begin
            if (enable) begin
                r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            end
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end
            if (load) begin
                r_shd_value <= value;
                r_shd_dp    <= dp_in;
                r_shd_blz   <= blank_lz;
            end
            // A load landing on the wrap bypasses the shadow so it is never left pending.
            if (w_wrap) begin
                if (load) begin
                    r_act_value <= value;
                    r_act_dp    <= dp_in;
                    r_act_blz   <= blank_lz;
                end else if (r_pending) begin
                    r_act_value <= r_shd_value;
                    r_act_dp    <= r_shd_dp;
                    r_act_blz   <= r_shd_blz;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_frame_start <= w_wrap;
            r_seg         <= w_seg_hi ^ SEG_POL;
            r_dp          <= (w_show && w_cur_dp) ^ SEG_ACTIVE_LOW;
            r_dig         <= w_dig_hi ^ DIG_POL;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign digit_sel   = r_dig;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_start;
    logic        pending;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        blz;
        logic [27:0] exp_seg;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs [5];

    hex_display_scanner #(
        .NUM_DIGITS     (4),
        .PRESCALE       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .digit_sel   (digit_sel),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        value    = v;
        dp_in    = d;
        blank_lz = b;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 64);
        check("frame_start_seen", {15'd0, frame_start}, 16'd1);
    endtask

    // Entered at a frame_start sample point; leaves at the next one.
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] sel_exp;
        check("dead_seg_f0", {9'd0, seg}, 16'h007F);
        check("dead_sel_f0", {12'd0, digit_sel}, 16'h000F);
        for (int d = 0; d < 4; d++) begin
            sel_exp = ~(4'b0001 << d);
            for (int k = 0; k < 3; k++) begin
                step();
                check($sformatf("seg_d%0d_c%0d", d, k), {9'd0, seg}, {9'd0, segs[7*d +: 7]});
                check($sformatf("sel_d%0d_c%0d", d, k), {12'd0, digit_sel}, {12'd0, sel_exp});
                check($sformatf("dp_d%0d_c%0d", d, k), {15'd0, dp}, {15'd0, dps[d]});
            end
            step();
            check($sformatf("dead_seg_d%0d", d), {9'd0, seg}, 16'h007F);
            check($sformatf("dead_sel_d%0d", d), {12'd0, digit_sel}, 16'h000F);
        end
        check("frame_start_next", {15'd0, frame_start}, 16'd1);
    endtask

    initial begin
        vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1111};
        vecs[1] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
        vecs[2] = '{16'h9876, 4'b1001, 1'b0, {7'h18, 7'h00, 7'h78, 7'h02}, 4'b0110};
        vecs[3] = '{16'hBCDE, 4'b0000, 1'b1, {7'h03, 7'h46, 7'h21, 7'h06}, 4'b1111};
        vecs[4] = '{16'h0205, 4'b0010, 1'b1, {7'h7F, 7'h24, 7'h40, 7'h12}, 4'b1101};

        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        step();
        step();
        check("rst_seg", {9'd0, seg}, 16'h007F);
        check("rst_sel", {12'd0, digit_sel}, 16'h000F);
        check("rst_dp", {15'd0, dp}, 16'd1);
        check("rst_fs", {15'd0, frame_start}, 16'd0);
        check("rst_pending", {15'd0, pending}, 16'd0);

        reset  = 1'b0;
        enable = 1'b1;
        wait_frame();
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        foreach (vecs[i]) begin
            do_load(vecs[i].value, vecs[i].dp_in, vecs[i].blz);
            check($sformatf("vec%0d_pending_set", i), {15'd0, pending}, 16'd1);
            wait_frame();
            check($sformatf("vec%0d_pending_clr", i), {15'd0, pending}, 16'd0);
            check_frame(vecs[i].exp_seg, vecs[i].exp_dp);
        end

        // Last load before the wrap wins.
        do_load(16'h0005, 4'b0000, 1'b1);
        do_load(16'h0050, 4'b0000, 1'b1);
        check("ovr_pending", {15'd0, pending}, 16'd1);
        wait_frame();
        check("ovr_pending_clr", {15'd0, pending}, 16'd0);
        check_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);

        // Load exactly on the wrap tick (state idx 3, prescale 3).
        repeat (15) step();
        value    = 16'h8888;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        load     = 1'b1;
        step();
        load     = 1'b0;
        check("wrap_load_fs", {15'd0, frame_start}, 16'd1);
        check("wrap_load_pending", {15'd0, pending}, 16'd0);
        check_frame({7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111);
        check("wrap_load_pending_after", {15'd0, pending}, 16'd0);

        // Freeze mid-slot of digit 0.
        step();
        step();
        check("pre_freeze_sel", {12'd0, digit_sel}, 16'h000E);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                value    = 16'h4444;
                dp_in    = 4'b0000;
                blank_lz = 1'b0;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
            check($sformatf("frz_seg_%0d", k), {9'd0, seg}, 16'h007F);
            check($sformatf("frz_sel_%0d", k), {12'd0, digit_sel}, 16'h000F);
        end
        load = 1'b0;
        check("frz_pending", {15'd0, pending}, 16'd1);
        enable = 1'b1;
        step();
        check("resume_sel", {12'd0, digit_sel}, 16'h000E);
        check("resume_seg", {9'd0, seg}, 16'h0000);
        step();
        check("resume_dead", {9'd0, seg}, 16'h007F);
        step();
        check("resume_next_sel", {12'd0, digit_sel}, 16'h000D);
        check("resume_next_seg", {9'd0, seg}, 16'h0000);
        wait_frame();
        check("frz_pending_clr", {15'd0, pending}, 16'd0);
        check_frame({7'h19, 7'h19, 7'h19, 7'h19}, 4'b1111);

        // Reset while a value is pending discards it.
        do_load(16'h0123, 4'b1111, 1'b0);
        check("rstp_pending_set", {15'd0, pending}, 16'd1);
        reset = 1'b1;
        step();
        check("rstp_seg", {9'd0, seg}, 16'h007F);
        check("rstp_sel", {12'd0, digit_sel}, 16'h000F);
        check("rstp_dp", {15'd0, dp}, 16'd1);
        check("rstp_pending", {15'd0, pending}, 16'd0);
        check("rstp_fs", {15'd0, frame_start}, 16'd0);
        reset = 1'b0;
        wait_frame();
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for NUM_DIGITS common-segment 7-segment displays. It generalises the single-nibble hex decoder into a sequential block.
- Captures a multi-nibble value through a load strobe and applies it only at frame boundaries, so the display never tears.
- Scans the digits one at a time with a dead cycle between slots, and supports leading-zero blanking, per-digit decimal points and selectable output polarity.
- Sits between the datapath result registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clock cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 1, 1: segment/dp pin low = lit; 0: high = lit.
- DIG_ACTIVE_LOW, 1, 1: digit_sel low = selected; 0: high = selected.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, 0 = freeze scan and force all outputs off.
- load, input, 1, 1-cycle strobe that captures value, dp_in and blank_lz.
- value, input, 4*NUM_DIGITS, nibble i = value[4i+3:4i]; digit 0 is least significant.
- dp_in, input, NUM_DIGITS, decimal point per digit.
- blank_lz, input, 1, enable leading-zero suppression.
- seg, output, 7, seg[0]=a .. seg[6]=g, registered.
- dp, output, 1, decimal point pin, registered.
- digit_sel, output, NUM_DIGITS, one-hot digit enable, registered.
- frame_start, output, 1, 1-cycle pulse when digit 0's slot begins.
- pending, output, 1, a loaded value is waiting for the frame boundary.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values:
  - prescaler=0, idx=0, shadow and active registers=0, pending=0, frame_start=0.
  - seg, dp and digit_sel all at their inactive level: seg=7'h7F when SEG_ACTIVE_LOW=1.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - tick asserts when the count is PRESCALE-1; the counter then wraps to 0.
  - On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Slot timing:
  - In the cycle after each tick, outputs are forced off (dead cycle, anti-ghosting).
  - For the remaining PRESCALE-1 cycles, the outputs show digit idx.
  - Output registers lag the internal state by 1 cycle.
- frame_start pulses in the same cycle the dead cycle for idx=0 is driven.
- Load handshake:
  - load=1 writes value/dp_in/blank_lz into the shadow register and sets pending=1.
  - A repeated load before transfer overwrites the shadow (last wins).
- Transfer to active:
  - Occurs on the tick where idx wraps NUM_DIGITS-1 -> 0; pending is cleared.
  - If load coincides with that tick, the incoming value goes directly to active and pending stays 0.
  - If NUM_DIGITS=1, every tick is a wrap.
- Glyphs (hex, active-high before polarity):
  - 0-9 standard; 6 with top bar; 7 = a,b,c; 9 without bottom bar.
  - A, b, C, d, E, F (b and d lowercase).
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked if nibbles i..NUM_DIGITS-1 are all 0 and i != 0. Digit 0 is always shown.
  - dp_in[i]=1 shows the dp even on a blanked digit.
- A blanked digit still receives its slot, with digit_sel active and seg off, so brightness stays uniform.
- enable=0:
  - prescaler and idx hold; outputs go off the next cycle.
  - load still captures into the shadow; transfer waits for scanning to resume.
- Reset mid-frame: everything returns to the reset values in the next cycle; the pending value is discarded.
- Polarity: outputs are XORed with the polarity parameters at the final register stage only.

Decomposition:
- Package hex_display_pkg:
  - SEG_W=7.
  - SEG_BLANK (active-high all-off).
  - Glyph constant table (16 x 7, active-high).
- Sub-module hex_glyph: combinational, 4-bit nibble in, 7-bit active-high segments out.
- The scanner instantiates one hex_glyph on the muxed nibble, not one per digit.

Test Plan:
- All tests use NUM_DIGITS=4, PRESCALE=4, both polarities active-low.
- Reset, then enable=1 with no load -> seg=7'h7F during dead cycles. First frame_start 1 cycle after the first wrap tick. Digit 0 shows 7'b1000000 (glyph 0), digit_sel=4'b1110. Each digit lit 3 of every 4 cycles.
- load value=16'h1A3F, blank_lz=0 mid-frame -> pending=1 until the wrap. Next frame shows F, 3, A, 1 on digits 0-3; pending=0 after the transfer.
- load 16'h0005 with blank_lz=1, then load 16'h0050 before the wrap -> only 0050 is displayed. Digits 3 and 2 are blank (seg=7'h7F with digit_sel active); digit 1 shows 5, digit 0 shows 0.
- load asserted exactly on the wrap tick with 16'h8888 -> active=8888 from that frame on, and pending never rises.
- enable=0 mid-slot for 10 cycles -> outputs off 1 cycle later and idx unchanged. On re-enable, the slot resumes with its remaining count.
- reset asserted while pending=1 -> next cycle all outputs off and pending=0. After release, the display shows 0 on digit 0 and 0 on the other digits.
